// File: rtl/msg_scroller.sv
// Scrolling-message source: a writable glyph buffer viewed through an 8-character
// window that slides one entry per programmable step, output as 32-bit digit codes.
module msg_scroller #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned MSG_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic        run,
  input  logic        dir,
  input  logic        restart,
  output logic [31:0] digits,
  output logic [3:0]  head,
  output logic        wrap
);

  localparam int unsigned    CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [3:0]     HEAD_LAST = 4'(MSG_LEN - 1);
  localparam logic [4:0]     LEN5      = 5'(MSG_LEN);

  logic [3:0]    r_mem [16];
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_head;
  logic          r_wrap;
  logic [31:0]   r_digits;

  logic          w_step;
  logic          w_wr_ok;
  logic [4:0]    w_idx;
  logic [31:0]   w_win;

  assign w_step  = run && (r_cnt == CNT_LAST);
  assign w_wr_ok = wr_en && ({1'b0, wr_addr} < LEN5);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) r_mem[i] <= 4'hF;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // head < MSG_LEN and j < 8 <= MSG_LEN, so one conditional subtract is a full modulo
  always_comb begin
    w_win = '1;
    w_idx = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      w_idx = {1'b0, r_head} + 5'(j);
      if (w_idx >= LEN5) w_idx = w_idx - LEN5;
      w_win[4*(7-j) +: 4] = r_mem[w_idx[3:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_head   <= '0;
      r_wrap   <= 1'b0;
      r_digits <= '1;
    end else begin
      r_digits <= w_win;
      if (restart) begin
        r_cnt  <= '0;
        r_head <= '0;
        r_wrap <= 1'b0;
      end else begin
        r_wrap <= 1'b0;
        if (run) r_cnt <= w_step ? '0 : r_cnt + CW'(1);
        if (w_step) begin
          if (!dir) begin
            if (r_head == HEAD_LAST) begin
              r_head <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_head <= r_head + 4'd1;
            end
          end else begin
            if (r_head == 4'd0) begin
              r_head <= HEAD_LAST;
              r_wrap <= 1'b1;
            end else begin
              r_head <= r_head - 4'd1;
            end
          end
        end
      end
    end
  end

  assign digits = r_digits;
  assign head   = r_head;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_msg_scroller.sv
// Bench for msg_scroller (TICK_DIV=4, MSG_LEN=10): per-cycle scoreboard against a
// reference model, plus directed checks of scroll, freeze, collision and reset cases.
module tb_msg_scroller;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        run;
  logic        dir;
  logic        restart;
  logic [31:0] digits;
  logic [3:0]  head;
  logic        wrap;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  msg_scroller #(.TICK_DIV(4), .MSG_LEN(10)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .dir(dir), .restart(restart), .digits(digits), .head(head), .wrap(wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [3:0]  m_mem [16];
  logic [3:0]  m_head;
  int          m_cnt;
  logic [36:0] sb_q [$];

  function automatic logic [31:0] win();
    logic [31:0] d;
    d = '1;
    for (int j = 0; j < 8; j++) d[4*(7-j) +: 4] = m_mem[4'((int'(m_head) + j) % 10)];
    return d;
  endfunction

  function automatic logic m_step();
    return run && (m_cnt == 3);
  endfunction

  function automatic logic [3:0] nhead();
    if (restart) return 4'd0;
    if (m_step()) return dir ? 4'((int'(m_head) + 9) % 10) : 4'((int'(m_head) + 1) % 10);
    return m_head;
  endfunction

  function automatic logic nwrap();
    return !restart && m_step() && (dir ? (m_head == 4'd0) : (m_head == 4'd9));
  endfunction

  function automatic int ncnt();
    if (restart) return 0;
    if (run) return (m_cnt == 3) ? 0 : m_cnt + 1;
    return m_cnt;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_mem[i] <= 4'hF;
      m_head <= 4'd0;
      m_cnt  <= 0;
      sb_q.push_back({32'hFFFF_FFFF, 4'd0, 1'b0});
    end else begin
      if (wr_en && wr_addr < 4'd10) m_mem[wr_addr] <= wr_data;
      sb_q.push_back({win(), nhead(), nwrap()});
      m_head <= nhead();
      m_cnt  <= ncnt();
    end
  end

  always @(negedge clk) begin
    logic [36:0] e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_digits", digits, e[36:5]);
      check("sb_head", 32'(head), 32'(e[4:1]));
      check("sb_wrap", 32'(wrap), 32'(e[0]));
    end
  end

  task automatic wait_change(input logic [3:0] prev, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (head == prev && n < maxc);
  endtask

  initial begin
    int n;
    int t0;
    logic [3:0] prev;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    run = 1'b0; dir = 1'b0; restart = 1'b0;

    // 1. reset and idle
    repeat (2) @(negedge clk);
    check("rst_digits", digits, 32'hFFFF_FFFF);
    check("rst_head", 32'(head), 0);
    check("rst_wrap", 32'(wrap), 0);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_head", 32'(head), 0);
    end

    // 2. load buffer, then an out-of-range write
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = (i < 8) ? 4'(i) : 4'hF;
      @(negedge clk);
    end
    wr_addr = 4'd12; wr_data = 4'h0;
    @(negedge clk);
    wr_en = 1'b0;
    check("load_digits", digits, 32'h0123_4567);
    @(negedge clk);
    check("badwr_digits", digits, 32'h0123_4567);
    check("badwr_head", 32'(head), 0);

    // 3. left scroll with wrap
    run = 1'b1; dir = 1'b0; t0 = cyc; prev = head;
    for (int k = 1; k <= 10; k++) begin
      wait_change(prev, 12, n);
      check("left_head", 32'(head), 32'(k % 10));
      check("left_interval", 32'(cyc - t0), 4);
      check("left_wrap", 32'(wrap), 32'(k == 10));
      t0 = cyc; prev = head;
      if (k == 1) begin
        @(negedge clk);
        check("left_digits_h1", digits, 32'h1234_567F);
      end
      if (k == 10) begin
        @(negedge clk);
        check("left_wrap_end", 32'(wrap), 0);
        dir = 1'b1;
      end
    end

    // 4. right scroll, then freeze
    wait_change(4'd0, 12, n);
    check("right_head", 32'(head), 9);
    check("right_interval", 32'(cyc - t0), 4);
    check("right_wrap", 32'(wrap), 1);
    @(negedge clk);
    check("right_digits", digits, 32'hF012_3456);
    check("right_wrap_end", 32'(wrap), 0);
    run = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("freeze_head", 32'(head), 9);
    end
    run = 1'b1;
    wait_change(4'd9, 12, n);
    check("resume_cycles", 32'(n), 3);
    check("resume_head", 32'(head), 8);

    // 5. collisions: restart in a step cycle, then write in a step cycle
    repeat (3) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_head", 32'(head), 0);
    check("restart_wrap", 32'(wrap), 0);
    repeat (3) @(negedge clk);
    wr_en = 1'b1; wr_addr = head; wr_data = 4'h5;
    @(negedge clk);
    wr_en = 1'b0;
    check("stepwr_head", 32'(head), 9);
    check("stepwr_wrap", 32'(wrap), 1);
    @(negedge clk);
    check("stepwr_digits", digits, 32'hF512_3456);

    // 6. reset mid-scroll at head=6, cnt=2, with a write pending
    n = 0;
    while (head != 4'd6 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_head6", 32'(head), 6);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'h0;
    @(negedge clk);
    check("midrst_head", 32'(head), 0);
    check("midrst_wrap", 32'(wrap), 0);
    check("midrst_digits", digits, 32'hFFFF_FFFF);
    rst_n = 1'b1; wr_en = 1'b0; run = 1'b1; dir = 1'b0; t0 = cyc;
    @(negedge clk);
    check("postrst_digits", digits, 32'hFFFF_FFFF);
    wait_change(4'd0, 12, n);
    check("postrst_head", 32'(head), 1);
    check("postrst_first_step", 32'(cyc - t0), 4);
    @(negedge clk);
    check("postrst_blank", digits, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
